// File: rtl/ysyx_23060072_wb_arbiter.sv
// Three-requester register-file writeback arbiter with one holding entry per port.
// Optional starvation protection is enabled by defining WB_ARB_AGING_EN.
module ysyx_23060072_wb_arbiter #(
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        pipe_valid_i,
    output logic        pipe_ready_o,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,

    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_data_i,

    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [4:0]  mdu_addr_i,
    input  logic [31:0] mdu_data_i,

    output logic        wb_flag_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_pending_o
);

    // Entry index doubles as fixed priority: 0 = pipe, 1 = lsu, 2 = mdu (highest).
    localparam int N = 3;

    logic [N-1:0] valid;
    logic [N-1:0] ready;
    logic [N-1:0] load;
    logic [N-1:0] grant;
    logic [N-1:0] cand;
    logic [4:0]   in_addr [N];
    logic [31:0]  in_data [N];

    logic [N-1:0] full_q, full_d;
    logic [4:0]   addr_q [N];
    logic [4:0]   addr_d [N];
    logic [31:0]  data_q [N];
    logic [31:0]  data_d [N];

    logic         wb_flag_q, wb_flag_d;
    logic [4:0]   wb_addr_q, wb_addr_d;
    logic [31:0]  wb_data_q, wb_data_d;
    logic         pending_q;

    assign valid      = {mdu_valid_i, lsu_valid_i, pipe_valid_i};
    assign in_addr[0] = pipe_addr_i;
    assign in_addr[1] = lsu_addr_i;
    assign in_addr[2] = mdu_addr_i;
    assign in_data[0] = pipe_data_i;
    assign in_data[1] = lsu_data_i;
    assign in_data[2] = mdu_data_i;

    assign pipe_ready_o = ready[0];
    assign lsu_ready_o  = ready[1];
    assign mdu_ready_o  = ready[2];

`ifdef WB_ARB_AGING_EN
    localparam logic [2:0] AGE_LIM = 3'(AGE_LIMIT);

    logic [2:0]   age_q [N];
    logic [2:0]   age_d [N];
    logic [N-1:0] promoted;
`else
    logic [2:0]   unused_age_limit;
    assign unused_age_limit = 3'(AGE_LIMIT);
`endif

    // Grant depends only on registered state, so ready never combinationally follows valid.
    always_comb begin
        cand = full_q;
`ifdef WB_ARB_AGING_EN
        if (|promoted) begin
            cand = promoted;
        end
`endif
        grant = '0;
        if (cand[2]) begin
            grant = 3'b100;
        end else if (cand[1]) begin
            grant = 3'b010;
        end else if (cand[0]) begin
            grant = 3'b001;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            assign ready[gi]  = ~full_q[gi] | grant[gi];
            assign load[gi]   = valid[gi] & ready[gi];
            assign full_d[gi] = load[gi] | (full_q[gi] & ~grant[gi]);
            assign addr_d[gi] = load[gi] ? in_addr[gi] : addr_q[gi];
            assign data_d[gi] = load[gi] ? in_data[gi] : data_q[gi];
`ifdef WB_ARB_AGING_EN
            assign promoted[gi] = full_q[gi] && (age_q[gi] >= AGE_LIM);
            assign age_d[gi] = (load[gi] || grant[gi]) ? 3'd0 :
                               (full_q[gi] && age_q[gi] != 3'd7) ? age_q[gi] + 3'd1 :
                               age_q[gi];
`endif
        end
    endgenerate

    // A granted x0 entry is drained but never raises the write enable.
    always_comb begin
        wb_flag_d = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                wb_flag_d = (addr_q[i] != 5'd0);
                wb_addr_d = addr_q[i];
                wb_data_d = data_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wb_flag_q <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            pending_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            full_q    <= full_d;
            wb_flag_q <= wb_flag_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            pending_q <= |full_d;
            for (int i = 0; i < N; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef WB_ARB_AGING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`endif

    assign wb_flag_o    = wb_flag_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign wb_pending_o = pending_q;

endmodule
